// File: rtl/n3l_pair_scheduler.sv
// -----------------------------------------------------------------------------
// n3l_pair_scheduler
//
// Walks the 27-cell neighbourhood of one reference cell in scan order
// k = 9*(dz+1) + 3*(dy+1) + (dx+1) and streams out the Newton's-3rd-law
// half-shell pairs: every offset whose first nonzero component (x, then y,
// then z) is +1, i.e. the 13 forward neighbours, plus the self pair at k=13
// when INCLUDE_SELF=1. Neighbour coordinates wrap periodically per axis.
// One candidate k is examined per cycle; skipped candidates never wait on the
// consumer, passing candidates wait for a free output register.
//
// Ports
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   start           begin a scan (ignored unless idle, or when abort is high)
//   abort           synchronous return to idle, pending pair discarded
//   ref_cell        reference cell {z,y,x}, sampled on an accepted start
//   grid_dim        cells per axis {z,y,x}, sampled on an accepted start
//   m_valid/m_ready pair stream handshake
//   m_ref, m_nbr    reference cell and wrapped neighbour cell of the pair
//   m_k             scan index of the pair (0..26)
//   m_last          final pair of this reference cell (k=26)
//   busy            high whenever the sequencer is not idle
//   done            one-cycle pulse when a scan completes
//   cfg_err         sticky flag for an unusable grid/reference configuration
//   pair_count      pairs handshaked since the last accepted start
// -----------------------------------------------------------------------------
module n3l_pair_scheduler #(
  parameter int CW           = 16,
  parameter bit INCLUDE_SELF = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [3*CW-1:0] ref_cell,
  input  logic [3*CW-1:0] grid_dim,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [3*CW-1:0] m_ref,
  output logic [3*CW-1:0] m_nbr,
  output logic [4:0]      m_k,
  output logic            m_last,
  output logic            busy,
  output logic            done,
  output logic            cfg_err,
  output logic [4:0]      pair_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [4:0] K_LAST = 5'd26;

  state_t          state;
  logic [4:0]      k;
  logic [3*CW-1:0] ref_q;
  logic [3*CW-1:0] dim_q;

  // Offset digits of the current candidate: 0 -> -1, 1 -> 0, 2 -> +1.
  logic [4:0]      kx, ky, kz;
  logic            k_pass;
  logic [3*CW-1:0] nbr;
  logic            cfg_bad;
  logic            out_free;

  // Half-shell rule: first nonzero offset component must be +1.
  function automatic logic pass_rule(input logic [4:0] dgx,
                                     input logic [4:0] dgy,
                                     input logic [4:0] dgz);
    logic p;
    if (dgx != 5'd1)      p = (dgx == 5'd2);
    else if (dgy != 5'd1) p = (dgy == 5'd2);
    else if (dgz != 5'd1) p = (dgz == 5'd2);
    else                  p = INCLUDE_SELF;
    return p;
  endfunction

  // Periodic wrap of one coordinate by an offset digit.
  function automatic logic [CW-1:0] wrap_axis(input logic [CW-1:0] c,
                                              input logic [CW-1:0] dim,
                                              input logic [4:0]    dg);
    logic [CW-1:0] r;
    case (dg)
      5'd0:    r = (c == '0) ? (dim - CW'(1)) : (c - CW'(1));
      5'd2:    r = (c == (dim - CW'(1))) ? '0 : (c + CW'(1));
      default: r = c;
    endcase
    return r;
  endfunction

  // Config is unusable when an axis is too small for distinct +/-1
  // neighbours or when the reference cell lies outside the grid.
  function automatic logic bad_cfg(input logic [3*CW-1:0] rc,
                                   input logic [3*CW-1:0] gd);
    logic b;
    b = 1'b0;
    for (int a = 0; a < 3; a++) begin
      if (gd[a*CW +: CW] < CW'(3))          b = 1'b1;
      if (rc[a*CW +: CW] >= gd[a*CW +: CW]) b = 1'b1;
    end
    return b;
  endfunction

  always_comb begin
    kx       = k % 5'd3;
    ky       = (k / 5'd3) % 5'd3;
    kz       = k / 5'd9;
    k_pass   = pass_rule(kx, ky, kz);
    nbr      = {wrap_axis(ref_q[2*CW +: CW], dim_q[2*CW +: CW], kz),
                wrap_axis(ref_q[CW   +: CW], dim_q[CW   +: CW], ky),
                wrap_axis(ref_q[0    +: CW], dim_q[0    +: CW], kx)};
    cfg_bad  = bad_cfg(ref_cell, grid_dim);
    out_free = !m_valid || m_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      k          <= '0;
      ref_q      <= '0;
      dim_q      <= '0;
      m_valid    <= 1'b0;
      m_ref      <= '0;
      m_nbr      <= '0;
      m_k        <= '0;
      m_last     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
      pair_count <= '0;
    end else begin
      done <= 1'b0;

      // A completed handshake empties the output register unless a new
      // pair is loaded in the same cycle (later assignment wins).
      if (m_valid && m_ready) begin
        pair_count <= pair_count + 5'd1;
        m_valid    <= 1'b0;
      end

      if (abort) begin
        state   <= IDLE;
        busy    <= 1'b0;
        m_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              ref_q      <= ref_cell;
              dim_q      <= grid_dim;
              k          <= '0;
              pair_count <= '0;
              busy       <= 1'b1;
              cfg_err    <= cfg_bad;
              state      <= cfg_bad ? DONE : SCAN;
            end
          end

          SCAN: begin
            if (!k_pass) begin
              // Skipped candidates never wait on the consumer.
              if (k == K_LAST) state <= DRAIN;
              else             k     <= k + 5'd1;
            end else if (out_free) begin
              m_valid <= 1'b1;
              m_ref   <= ref_q;
              m_nbr   <= nbr;
              m_k     <= k;
              m_last  <= (k == K_LAST);
              if (k == K_LAST) state <= DRAIN;
              else             k     <= k + 5'd1;
            end
          end

          DRAIN: begin
            if (out_free) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end

          DONE: begin
            // Arriving from DRAIN the pulse is already up; arriving from a
            // bad config it is raised here, one cycle later.
            if (done) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              done <= 1'b1;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_n3l_pair_scheduler.sv
module tb_n3l_pair_scheduler;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start0 = 1'b0, start1 = 1'b0;
  logic            abort = 1'b0;
  logic            m_ready = 1'b0;
  logic [3*CW-1:0] ref_cell = '0, grid_dim = '0;

  logic            v0, v1, l0, l1, b0, b1, d0, d1, e0, e1;
  logic [3*CW-1:0] r0, r1, n0, n1;
  logic [4:0]      k0, k1, c0, c1;

  bit              sel = 1'b0;
  logic            mv, ml, mb, md, me;
  logic [3*CW-1:0] mr, mn;
  logic [4:0]      mk, mc;

  assign mv = sel ? v1 : v0;
  assign ml = sel ? l1 : l0;
  assign mb = sel ? b1 : b0;
  assign md = sel ? d1 : d0;
  assign me = sel ? e1 : e0;
  assign mr = sel ? r1 : r0;
  assign mn = sel ? n1 : n0;
  assign mk = sel ? k1 : k0;
  assign mc = sel ? c1 : c0;

  n3l_pair_scheduler #(.CW(CW), .INCLUDE_SELF(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort),
    .ref_cell(ref_cell), .grid_dim(grid_dim),
    .m_valid(v0), .m_ready(m_ready), .m_ref(r0), .m_nbr(n0), .m_k(k0),
    .m_last(l0), .busy(b0), .done(d0), .cfg_err(e0), .pair_count(c0));

  n3l_pair_scheduler #(.CW(CW), .INCLUDE_SELF(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort),
    .ref_cell(ref_cell), .grid_dim(grid_dim),
    .m_valid(v1), .m_ready(m_ready), .m_ref(r1), .m_nbr(n1), .m_k(k1),
    .m_last(l1), .busy(b1), .done(d1), .cfg_err(e1), .pair_count(c1));

  always #5 clk = ~clk;

  typedef struct {
    int rx, ry, rz;
    int dx, dy, dz;
    bit incl;
    int rmode;      // 0: always ready, 1: pattern 1,0,0, 2: random
    bit exp_err;
    int exp_pairs;
    int exp_done;   // cycle of done pulse, -1 = not checked
  } vec_t;

  typedef struct packed {
    logic [4:0]      k;
    logic [3*CW-1:0] nbr;
    logic            last;
  } pair_t;

  pair_t expq[$];
  int    total = 0;
  int    passed = 0;
  vec_t  tbl[8];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic bit model_err(input vec_t v);
    return (v.dx < 3) || (v.dy < 3) || (v.dz < 3) ||
           (v.rx >= v.dx) || (v.ry >= v.dy) || (v.rz >= v.dz);
  endfunction

  // Reference model: enumerate offsets in scan order and apply the
  // half-shell rule and modular wrap directly.
  task automatic build_model(input vec_t v);
    int ox, oy, oz, nx, ny, nz;
    bit p;
    pair_t e;
    expq.delete();
    if (model_err(v)) return;
    for (int kk = 0; kk < 27; kk++) begin
      ox = kk % 3 - 1;
      oy = (kk / 3) % 3 - 1;
      oz = kk / 9 - 1;
      if (ox != 0)      p = (ox == 1);
      else if (oy != 0) p = (oy == 1);
      else if (oz != 0) p = (oz == 1);
      else              p = v.incl;
      if (p) begin
        nx = (v.rx + ox + v.dx) % v.dx;
        ny = (v.ry + oy + v.dy) % v.dy;
        nz = (v.rz + oz + v.dz) % v.dz;
        e.k    = 5'(kk);
        e.nbr  = {CW'(nz), CW'(ny), CW'(nx)};
        e.last = (kk == 26);
        expq.push_back(e);
      end
    end
  endtask

  function automatic logic rdy(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (c % 3) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run(input vec_t v, input string nm);
    int cyc, nhs, first, donec;
    bit anyv, pv, pr;
    logic [102:0] prev, cur;
    logic [3*CW-1:0] refv;
    pair_t e;
    sel = v.incl;
    build_model(v);
    refv = {CW'(v.rz), CW'(v.ry), CW'(v.rx)};
    @(posedge clk); #1;
    ref_cell = refv;
    grid_dim = {CW'(v.dz), CW'(v.dy), CW'(v.dx)};
    if (v.incl) start1 = 1'b1; else start0 = 1'b1;
    cyc = 0; nhs = 0; first = -1; donec = -1; anyv = 0; pv = 0; pr = 0; prev = '0;
    m_ready = rdy(v.rmode, 0);
    while (donec < 0 && cyc < 400) begin
      @(negedge clk);
      cur = {mv, mk, mr, ml, mn};
      if (pv && !pr) chk({nm, " stall_hold"}, 128'(cur), 128'(prev));
      if (mv) begin
        anyv = 1;
        if (first < 0) first = cyc;
      end
      if (mv && m_ready) begin
        nhs++;
        if (expq.size() == 0) chk({nm, " extra_pair"}, 128'(mk), 128'(5'h1f));
        else begin
          e = expq.pop_front();
          chk({nm, " pair"}, 128'({mk, mr, mn, ml}), 128'({e.k, refv, e.nbr, e.last}));
        end
      end
      if (md) donec = cyc;
      prev = cur; pv = mv; pr = m_ready;
      @(posedge clk); #1;
      start0 = 1'b0; start1 = 1'b0;
      cyc++;
      m_ready = rdy(v.rmode, cyc);
    end
    if (donec < 0) chk({nm, " done_timeout"}, 128'(0), 128'(1));
    @(negedge clk);
    chk({nm, " busy_after_done"}, 128'(mb), 128'(0));
    chk({nm, " pair_count"}, 128'(mc), 128'(v.exp_pairs));
    chk({nm, " handshakes"}, 128'(nhs), 128'(v.exp_pairs));
    chk({nm, " cfg_err"}, 128'(me), 128'(v.exp_err));
    chk({nm, " pairs_left"}, 128'(expq.size()), 128'(0));
    if (v.exp_done >= 0) chk({nm, " done_cycle"}, 128'(donec), 128'(v.exp_done));
    if (v.exp_err) chk({nm, " no_valid"}, 128'(anyv), 128'(0));
    else if (v.rmode == 0) chk({nm, " first_valid_cycle"}, 128'(first), 128'(4));
  endtask

  task automatic watch_quiet(input string nm, input int n);
    int dn, vn;
    dn = 0; vn = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (md) dn++;
      if (mv) vn++;
    end
    chk({nm, " no_done"}, 128'(dn), 128'(0));
    chk({nm, " no_valid"}, 128'(vn), 128'(0));
  endtask

  initial begin
    vec_t rv;
    int nhs, c;

    //        rx ry rz  dx dy dz incl mode err pairs done
    tbl[0] = '{1, 1, 1, 4, 4, 4, 0, 0, 0, 13, 29};
    tbl[1] = '{0, 3, 0, 4, 4, 4, 0, 0, 0, 13, 29};
    tbl[2] = '{2, 2, 2, 5, 5, 5, 1, 0, 0, 14, 29};
    tbl[3] = '{1, 1, 1, 4, 4, 4, 0, 1, 0, 13, -1};
    tbl[4] = '{0, 0, 0, 2, 4, 4, 0, 0, 1, 0, 2};
    tbl[5] = '{4, 1, 1, 4, 4, 4, 0, 0, 1, 0, 2};
    tbl[6] = '{2, 2, 2, 3, 3, 3, 1, 2, 0, 14, -1};
    tbl[7] = '{0, 0, 0, 3, 3, 3, 0, 0, 0, 13, 29};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs_0", 128'({v0, b0, d0, e0, c0, k0, l0, n0, r0}), 128'(0));
    chk("reset_outputs_1", 128'({v1, b1, d1, e1, c1, k1, l1, n1, r1}), 128'(0));
    @(posedge clk); #1 rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run(tbl[i], $sformatf("vec%0d", i));

    // abort after the 5th transfer
    sel = 0;
    @(posedge clk); #1;
    ref_cell = {16'd1, 16'd1, 16'd1}; grid_dim = {16'd4, 16'd4, 16'd4};
    start0 = 1'b1; m_ready = 1'b1; nhs = 0; c = 0;
    while (nhs < 5 && c < 60) begin
      @(negedge clk);
      if (mv && m_ready) nhs++;
      @(posedge clk); #1 start0 = 1'b0; c++;
    end
    chk("abort_reach5", 128'(nhs), 128'(5));
    m_ready = 1'b0; abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_valid_drop", 128'(mv), 128'(0));
    chk("abort_busy", 128'(mb), 128'(0));
    chk("abort_count_hold", 128'(mc), 128'(5));
    watch_quiet("abort", 40);
    run(tbl[0], "after_abort");

    // reset in cycle 10 of a scan
    sel = 0;
    @(posedge clk); #1;
    ref_cell = {16'd1, 16'd1, 16'd1}; grid_dim = {16'd4, 16'd4, 16'd4};
    start0 = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1 start0 = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", 128'({v0, b0, d0, e0, c0, k0, l0, n0, r0}), 128'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    watch_quiet("rst_mid", 40);
    run(tbl[0], "after_reset");

    // randomized configurations against the model
    for (int i = 0; i < 12; i++) begin
      rv.dx = $urandom_range(2, 6); rv.dy = $urandom_range(3, 6); rv.dz = $urandom_range(3, 6);
      rv.rx = $urandom_range(0, rv.dx - 1);
      rv.ry = $urandom_range(0, rv.dy - 1);
      rv.rz = $urandom_range(0, rv.dz);
      rv.incl = 1'($urandom_range(0, 1));
      rv.rmode = 2;
      rv.exp_err = model_err(rv);
      rv.exp_pairs = rv.exp_err ? 0 : (rv.incl ? 14 : 13);
      rv.exp_done = rv.exp_err ? 2 : -1;
      run(rv, $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
